// File: rtl/rv32i_decode_queue.sv
// rv32i_decode_queue
// ------------------
// Multi-lane RV32I decode stage with a circular instruction queue. It sits
// between fetch and issue. Up to WIDTH instructions are decoded at enqueue
// and stored with their PC and raw encoding. The WIDTH oldest entries are
// presented on the out_* lanes each cycle, and the consumer retires 0..WIDTH
// of them.
//
// Optional feature (macro RV32I_DECODE_QUEUE_BYPASS_EN):
//   When the macro is defined, the queue is empty, and flush is low, the
//   incoming lanes are decoded and shown on out_* in the same cycle. Lanes
//   consumed that cycle are not written. The remaining lanes are enqueued
//   normally.
//   When the macro is undefined, outputs always come from queue storage,
//   one cycle after enqueue.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   flush               discard every queued entry (redirect)
//   in_valid[WIDTH]     per-lane valid; only the leading run of ones counts
//   in_instr, in_pc     WIDTH*XLEN instruction words / PCs, lane i at [i*XLEN +: XLEN]
//   in_ready            a full group of WIDTH entries fits (registered count only)
//   out_valid[WIDTH]    thermometer: lane i valid iff occupancy > i
//   out_control_word    WIDTH*26 decoded control words
//   out_branch_sel      WIDTH*3 branch selects
//   out_pc, out_instr   stored PC and raw instruction per lane
//   out_illegal         lane holds an undecodable instruction
//   out_consume         number of head entries retired this cycle (clamped to count)
//   count               current occupancy

module rv32i_decode_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             in_valid,
    input  logic [WIDTH*XLEN-1:0]        in_instr,
    input  logic [WIDTH*XLEN-1:0]        in_pc,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_valid,
    output logic [WIDTH*26-1:0]          out_control_word,
    output logic [WIDTH*3-1:0]           out_branch_sel,
    output logic [WIDTH*XLEN-1:0]        out_pc,
    output logic [WIDTH*XLEN-1:0]        out_instr,
    output logic [WIDTH-1:0]             out_illegal,
    input  logic [$clog2(WIDTH+1)-1:0]   out_consume,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int NW = $clog2(WIDTH+1);

    // Decoded word layout: {illegal, branch_sel[2:0], control_word[25:0]}
    function automatic logic [29:0] decode(input logic [31:0] instr);
        logic [6:0] op;
        logic [2:0] f3;
        logic       r, i_alu, ld, jalr, s, b, lui, auipc, jal;
        logic       i_t, u, we, use_imm, save_pc, illegal;
        logic [3:0] fsel;
        logic [2:0] bsel, mw;
        logic [4:0] rd, rs1, rs2;
        op      = instr[6:0];
        f3      = instr[14:12];
        r       = (op == 7'b0110011);
        i_alu   = (op == 7'b0010011);
        ld      = (op == 7'b0000011);
        jalr    = (op == 7'b1100111);
        s       = (op == 7'b0100011);
        b       = (op == 7'b1100011);
        lui     = (op == 7'b0110111);
        auipc   = (op == 7'b0010111);
        jal     = (op == 7'b1101111);
        i_t     = i_alu | ld | jalr;
        u       = lui | auipc;
        we      = r | i_t | u | jal;
        use_imm = i_t | s | u | jal;
        save_pc = jalr | auipc | jal;
        illegal = !(r | i_alu | ld | jalr | s | b | lui | auipc | jal)
                | (b  && (f3[2:1] == 2'b01))
                | (ld && ((f3 == 3'b011) || (f3[2:1] == 2'b11)))
                | (s  && (f3 >= 3'b011));

        fsel = 4'b0000;
        if (r | i_alu) begin
            case (f3)
                3'b000:  fsel = r ? {3'b000, instr[30]} : 4'b0000;
                3'b001:  fsel = 4'b1000;
                3'b010:  fsel = 4'b0010;
                3'b011:  fsel = 4'b0011;
                3'b100:  fsel = 4'b0100;
                3'b101:  fsel = instr[30] ? 4'b1001 : 4'b1010;
                3'b110:  fsel = 4'b0101;
                default: fsel = 4'b0110;
            endcase
        end else if (b) begin
            fsel = (f3[2:1] == 2'b11) ? 4'b0011 : 4'b0001;
        end

        bsel = 3'b000;
        if (jalr) begin
            bsel = 3'b111;
        end else if (jal) begin
            bsel = 3'b110;
        end else if (b) begin
            case (f3)
                3'b000:         bsel = 3'b010;
                3'b001:         bsel = 3'b011;
                3'b100, 3'b110: bsel = 3'b100;
                3'b101, 3'b111: bsel = 3'b101;
                default:        bsel = 3'b000;
            endcase
        end

        mw  = (ld | s) ? f3 : 3'b000;
        rd  = we ? instr[11:7] : 5'd0;
        rs1 = (u | jal) ? 5'd0 : instr[19:15];
        rs2 = instr[24:20];

        if (illegal)
            decode = {1'b1, 29'd0};
        else
            decode = {1'b0, bsel, rd, rs2, rs1, fsel, we, save_pc, ld, use_imm, mw};
    endfunction

    // Queue storage (data only; occupancy is tracked by head/tail/count)
    logic [25:0]     cw_mem    [DEPTH];
    logic [2:0]      bsel_mem  [DEPTH];
    logic            ill_mem   [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [PW-1:0] head, tail;
    logic [NW-1:0] n_in;
    logic [CW-1:0] n_in_ext, n_out, n_skip, n_wr, consume_ext;
    logic          wr_en, bypass;
    logic [29:0]   dec     [WIDTH];
    logic [PW-1:0] wr_slot [WIDTH];

    always_comb begin
        n_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Extends only while every earlier lane was valid.
            if (in_valid[i] && (n_in == NW'(i)))
                n_in = NW'(i + 1);
        end
        n_in_ext    = CW'(n_in);
        consume_ext = CW'(out_consume);
        n_out       = (consume_ext > count) ? count : consume_ext;
        in_ready    = ((CW'(DEPTH) - count) >= CW'(WIDTH));

`ifdef RV32I_DECODE_QUEUE_BYPASS_EN
        bypass = (count == '0) && !flush;
`else
        bypass = 1'b0;
`endif
        // Lanes taken straight from the inputs by the consumer are not stored.
        n_skip = '0;
        if (bypass)
            n_skip = (consume_ext > n_in_ext) ? n_in_ext : consume_ext;

        wr_en = in_ready && !flush && (n_in != '0);
        n_wr  = wr_en ? (n_in_ext - n_skip) : '0;

        for (int i = 0; i < WIDTH; i++) begin
            dec[i]     = decode(in_instr[i*XLEN +: 32]);
            wr_slot[i] = tail + PW'(i) - PW'(n_skip);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(n_out);
            tail  <= tail + PW'(n_wr);
            count <= count + n_wr - n_out;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en && (CW'(i) >= n_skip) && (CW'(i) < n_in_ext)) begin
                cw_mem[wr_slot[i]]    <= dec[i][25:0];
                bsel_mem[wr_slot[i]]  <= dec[i][28:26];
                ill_mem[wr_slot[i]]   <= dec[i][29];
                pc_mem[wr_slot[i]]    <= in_pc[i*XLEN +: XLEN];
                instr_mem[wr_slot[i]] <= in_instr[i*XLEN +: XLEN];
            end
        end
    end

    // Output lanes: lane i shows slot head+i. Invalid lanes are forced to zero.
    always_comb begin
        out_valid        = '0;
        out_control_word = '0;
        out_branch_sel   = '0;
        out_pc           = '0;
        out_instr        = '0;
        out_illegal      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bypass) begin
                if (CW'(i) < n_in_ext) begin
                    out_valid[i]               = 1'b1;
                    out_control_word[i*26 +: 26] = dec[i][25:0];
                    out_branch_sel[i*3 +: 3]   = dec[i][28:26];
                    out_illegal[i]             = dec[i][29];
                    out_pc[i*XLEN +: XLEN]     = in_pc[i*XLEN +: XLEN];
                    out_instr[i*XLEN +: XLEN]  = in_instr[i*XLEN +: XLEN];
                end
            end else if (count > CW'(i)) begin
                out_valid[i]                 = 1'b1;
                out_control_word[i*26 +: 26] = cw_mem[head + PW'(i)];
                out_branch_sel[i*3 +: 3]     = bsel_mem[head + PW'(i)];
                out_illegal[i]               = ill_mem[head + PW'(i)];
                out_pc[i*XLEN +: XLEN]       = pc_mem[head + PW'(i)];
                out_instr[i*XLEN +: XLEN]    = instr_mem[head + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Testbench for rv32i_decode_queue (default build, WIDTH=2, DEPTH=8).
// A queue-based reference model is checked against the DUT on every falling
// edge, with literal expectations taken from the hand-decoded test plan.

module tb_rv32i_decode_queue;

    localparam int WIDTH = 2;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;

    logic                 clk = 1'b0;
    logic                 reset, flush;
    logic [WIDTH-1:0]     in_valid;
    logic [WIDTH*XLEN-1:0] in_instr, in_pc;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_valid;
    logic [WIDTH*26-1:0]  out_control_word;
    logic [WIDTH*3-1:0]   out_branch_sel;
    logic [WIDTH*XLEN-1:0] out_pc, out_instr;
    logic [WIDTH-1:0]     out_illegal;
    logic [1:0]           out_consume;
    logic [3:0]           count;

    rv32i_decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid),
        .out_control_word(out_control_word), .out_branch_sel(out_branch_sel),
        .out_pc(out_pc), .out_instr(out_instr), .out_illegal(out_illegal),
        .out_consume(out_consume), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    int          checks   = 0;
    int          failures = 0;
    bit          model_on = 0;
    logic [31:0] pc_ctr   = 32'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic b30, input bit is_r);
        case (f3)
            3'd0: return is_r ? {3'b000, b30} : 4'd0;
            3'd1: return 4'd8;
            3'd2: return 4'd2;
            3'd3: return 4'd3;
            3'd4: return 4'd4;
            3'd5: return b30 ? 4'd9 : 4'd10;
            3'd6: return 4'd5;
            default: return 4'd6;
        endcase
    endfunction

    // Reference decode, from the type table: {illegal, branch_sel, control_word}
    function automatic logic [29:0] ref_decode(input logic [31:0] x);
        logic [2:0] f3, bs, mw;
        logic [3:0] fs;
        logic [4:0] rs1;
        logic       we, sp, ld, ui;
        bit         ok;
        f3 = x[14:12]; ok = 1; we = 0; sp = 0; ld = 0; ui = 0;
        fs = 0; bs = 0; mw = 0; rs1 = x[19:15];
        case (x[6:0])
            7'h33: begin we = 1; fs = alu_sel(f3, x[30], 1); end
            7'h13: begin we = 1; ui = 1; fs = alu_sel(f3, x[30], 0); end
            7'h03: begin we = 1; ui = 1; ld = 1; mw = f3; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'h67: begin we = 1; ui = 1; sp = 1; bs = 3'b111; end
            7'h23: begin ui = 1; mw = f3; ok = (f3 < 3'd3); end
            7'h63: begin
                ok = !(f3 inside {3'd2, 3'd3});
                fs = (f3 >= 3'd6) ? 4'd3 : 4'd1;
                case (f3)
                    3'd0: bs = 3'b010;
                    3'd1: bs = 3'b011;
                    3'd4, 3'd6: bs = 3'b100;
                    3'd5, 3'd7: bs = 3'b101;
                    default: bs = 3'b000;
                endcase
            end
            7'h37: begin we = 1; ui = 1; rs1 = 0; end
            7'h17: begin we = 1; ui = 1; sp = 1; rs1 = 0; end
            7'h6F: begin we = 1; ui = 1; sp = 1; rs1 = 0; bs = 3'b110; end
            default: ok = 0;
        endcase
        if (!ok) return {1'b1, 29'd0};
        return {1'b0, bs, (we ? x[11:7] : 5'd0), x[24:20], rs1, fs, we, sp, ld, ui, mw};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 10))
            0: x[6:0] = 7'h33;  1: x[6:0] = 7'h13;  2: x[6:0] = 7'h03;
            3: x[6:0] = 7'h67;  4: x[6:0] = 7'h23;  5: x[6:0] = 7'h63;
            6: x[6:0] = 7'h37;  7: x[6:0] = 7'h17;  8: x[6:0] = 7'h6F;
            default: ;
        endcase
        return x;
    endfunction

    // Applies one clock edge of the specification's rules to the model queue.
    task automatic model_update();
        int   n_in, n_out;
        bit   ready;
        ent_t e;
        if (reset || flush) begin
            q.delete();
            return;
        end
        ready = (DEPTH - q.size()) >= WIDTH;
        n_in = 0;
        while (n_in < WIDTH && in_valid[n_in]) n_in++;
        n_out = (int'(out_consume) < q.size()) ? int'(out_consume) : q.size();
        for (int k = 0; k < n_out; k++) void'(q.pop_front());
        if (ready) begin
            for (int k = 0; k < n_in; k++) begin
                e.instr = in_instr[k*XLEN +: XLEN];
                e.pc    = in_pc[k*XLEN +: XLEN];
                q.push_back(e);
            end
        end
    endtask

    // Compare process: DUT against the model on every falling edge.
    initial begin
        logic [51:0]  e_cw;
        logic [5:0]   e_bs;
        logic [1:0]   e_v, e_ill;
        logic [63:0]  e_pc, e_in;
        logic [29:0]  d;
        forever begin
            @(negedge clk);
            if (model_on) begin
                e_cw = '0; e_bs = '0; e_v = '0; e_ill = '0; e_pc = '0; e_in = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i < q.size()) begin
                        d = ref_decode(q[i].instr);
                        e_v[i]          = 1'b1;
                        e_ill[i]        = d[29];
                        e_bs[i*3 +: 3]  = d[28:26];
                        e_cw[i*26 +: 26] = d[25:0];
                        e_pc[i*32 +: 32] = q[i].pc;
                        e_in[i*32 +: 32] = q[i].instr;
                    end
                end
                chk("model_count", 64'(count), 64'(q.size()));
                chk("model_in_ready", 64'(in_ready), 64'((DEPTH - q.size()) >= WIDTH));
                chk("model_out_valid", 64'(out_valid), 64'(e_v));
                chk("model_cw", 64'(out_control_word), 64'(e_cw));
                chk("model_bsel", 64'(out_branch_sel), 64'(e_bs));
                chk("model_illegal", 64'(out_illegal), 64'(e_ill));
                chk("model_pc", out_pc, e_pc);
                chk("model_instr", out_instr, e_in);
            end
        end
    end

    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] cons, input logic fl, input logic rs);
        in_valid    = v;
        in_instr    = {i1, i0};
        in_pc       = {pc_ctr + 32'd4, pc_ctr};
        pc_ctr      = pc_ctr + 32'd8;
        out_consume = cons;
        flush       = fl;
        reset       = rs;
        @(posedge clk);
        model_update();
        if (rs) model_on = 1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_consume = 0;

        // Reset state
        step(2'b11, 32'h0000_0033, 32'h0000_0033, 2'd0, 1'b0, 1'b1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_cw", 64'(out_control_word), 64'd0);

        // ADD x3,x1,x2 in lane 0, lane 1 invalid
        step(2'b01, 32'h0020_81B3, 32'h0000_0063, 2'd0, 1'b0, 1'b0);
        chk("add_valid", 64'(out_valid), 64'b01);
        chk("add_cw", 64'(out_control_word[25:0]), 64'h620840);
        chk("add_bsel", 64'(out_branch_sel[2:0]), 64'd0);
        chk("add_illegal", 64'(out_illegal), 64'd0);
        step(2'b00, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);

        // BEQ x0,x0 and JALR x1,0(x1)
        step(2'b11, 32'h0000_0063, 32'h0000_80E7, 2'd0, 1'b0, 1'b0);
        chk("beq_cw", 64'(out_control_word[25:0]), 64'h000080);
        chk("beq_bsel", 64'(out_branch_sel[2:0]), 64'd2);
        chk("jalr_bsel", 64'(out_branch_sel[5:3]), 64'd7);
        chk("jalr_cw", 64'(out_control_word[51:26]), 64'h200868);
        step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);

        // Illegal encodings
        step(2'b11, 32'hFFFF_FFFF, 32'h0000_7003, 2'd0, 1'b0, 1'b0);
        chk("ill_flags", 64'(out_illegal), 64'b11);
        chk("ill_cw", 64'(out_control_word), 64'd0);
        chk("ill_count", 64'(count), 64'd2);
        step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);

        // Fill to full, rejected push, then stream through a pointer wrap
        for (int k = 0; k < 4; k++) step(2'b11, gen_instr(), gen_instr(), 2'd0, 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        step(2'b11, gen_instr(), gen_instr(), 2'd2, 1'b0, 1'b0);
        chk("reject_count", 64'(count), 64'd6);
        for (int k = 0; k < 6; k++) step(2'b11, gen_instr(), gen_instr(), 2'd2, 1'b0, 1'b0);
        chk("wrap_count", 64'(count), 64'd6);

        // Flush beats simultaneous push and consume
        step(2'b11, gen_instr(), gen_instr(), 2'd2, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);

        // Over-consume clamps at occupancy
        step(2'b01, gen_instr(), gen_instr(), 2'd0, 1'b0, 1'b0);
        chk("one_count", 64'(count), 64'd1);
        step(2'b00, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        chk("clamp_count", 64'(count), 64'd0);

        // Randomized traffic
        for (int k = 0; k < 600; k++) begin
            step(2'($urandom_range(0, 3)), gen_instr(), gen_instr(),
                 2'($urandom_range(0, 2)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 149) == 0));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
